// File: rtl/y86_pkg.sv
// Shared Y86 constants: icodes, ALU function codes, ZSO bit positions and CC reset value.
package y86_pkg;
    localparam logic [3:0] IOPQ   = 4'h6;
    localparam logic [3:0] ALUADD = 4'h0;
    localparam logic [3:0] ALUSUB = 4'h1;
    localparam logic [3:0] ALUAND = 4'h2;
    localparam logic [3:0] ALUXOR = 4'h3;

    localparam int ZF_B = 2;
    localparam int SF_B = 1;
    localparam int OF_B = 0;

    localparam logic [2:0] CC_RST = 3'b100;
endpackage

// File: rtl/cc_flags.sv
// Combinational ZF/SF/OF generator for the execute-stage ALU result.
module cc_flags
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [3:0]   ifun,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] res,
    output logic [2:0]   flags
);
    logic of;

    always_comb begin
        of = 1'b0;
        case (ifun)
            ALUADD:  of = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            // sub computes b - a, so overflow is judged against b's sign
            ALUSUB:  of = (a[W-1] != b[W-1]) && (res[W-1] != b[W-1]);
            default: of = 1'b0;
        endcase
    end

    always_comb begin
        flags       = 3'b000;
        flags[ZF_B] = (res == '0);
        flags[SF_B] = res[W-1];
        flags[OF_B] = of;
    end
endmodule

// File: rtl/cc_reg.sv
// Y86 condition-code register: gated ZSO latch with exception freeze.
// Optional committed-update counter enabled by defining CC_UPDCNT_EN.
module cc_reg
    import y86_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         e_valid,
    input  logic [3:0]   e_icode,
    input  logic [3:0]   e_ifun,
    input  logic [W-1:0] alu_a,
    input  logic [W-1:0] alu_b,
    input  logic [W-1:0] alu_res,
    input  logic         e_stall,
    input  logic         m_exc,
    input  logic         w_exc,
    output logic [2:0]   zso,
    output logic         frozen
`ifdef CC_UPDCNT_EN
    ,
    output logic [31:0]  upd_cnt
`endif
);
    logic [2:0] flags;
    logic [2:0] zso_q, zso_d;
    logic       frozen_q, frozen_d;
    logic       set_cc;

    cc_flags #(.W(W)) u_flags (
        .ifun  (e_ifun),
        .a     (alu_a),
        .b     (alu_b),
        .res   (alu_res),
        .flags (flags)
    );

    // m_exc only blocks the update; the memory-stage instruction may yet be squashed
    assign set_cc = e_valid && (e_icode == IOPQ) && (e_ifun <= ALUXOR)
                 && !e_stall && !m_exc && !w_exc && !frozen_q;

    always_comb begin
        zso_d    = zso_q;
        frozen_d = frozen_q;
        if (set_cc) zso_d = flags;
        if (w_exc)  frozen_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zso_q    <= CC_RST;
            frozen_q <= 1'b0;
        end else begin
            zso_q    <= zso_d;
            frozen_q <= frozen_d;
        end
    end

    assign zso    = zso_q;
    assign frozen = frozen_q;

`ifdef CC_UPDCNT_EN
    logic [31:0] upd_cnt_q, upd_cnt_d;

    always_comb begin
        upd_cnt_d = upd_cnt_q;
        if (set_cc) upd_cnt_d = upd_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) upd_cnt_q <= 32'd0;
        else        upd_cnt_q <= upd_cnt_d;
    end

    assign upd_cnt = upd_cnt_q;
`endif
endmodule

// File: tb/tb_cc_reg.sv
// Testbench for cc_reg: vector table with an expected-value queue, plus reset/counter sequences.
module tb_cc_reg;
    localparam int W = 64;
    localparam logic [63:0] MSB  = 64'h8000_0000_0000_0000;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         e_valid;
    logic [3:0]   e_icode;
    logic [3:0]   e_ifun;
    logic [W-1:0] alu_a, alu_b, alu_res;
    logic         e_stall, m_exc, w_exc;
    logic [2:0]   zso;
    logic         frozen;
`ifdef CC_UPDCNT_EN
    logic [31:0]  upd_cnt;
`endif

    cc_reg #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .e_valid (e_valid),
        .e_icode (e_icode),
        .e_ifun  (e_ifun),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_res (alu_res),
        .e_stall (e_stall),
        .m_exc   (m_exc),
        .w_exc   (w_exc),
        .zso     (zso),
        .frozen  (frozen)
`ifdef CC_UPDCNT_EN
        ,
        .upd_cnt (upd_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  ic;
        logic [3:0]  fn;
        logic [63:0] a, b, r;
        logic        st, me, we;
        logic [2:0]  ez;
        logic        ef;
    } vec_t;

    typedef struct {
        int         idx;
        logic [2:0] ez;
        logic       ef;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(logic v, logic [3:0] ic, logic [3:0] fn,
                                logic [63:0] a, logic [63:0] b, logic [63:0] r,
                                logic st, logic me, logic we,
                                logic [2:0] ez, logic ef);
        vec_t t;
        t.v = v; t.ic = ic; t.fn = fn; t.a = a; t.b = b; t.r = r;
        t.st = st; t.me = me; t.we = we; t.ez = ez; t.ef = ef;
        return t;
    endfunction

    task automatic check3(string name, logic [2:0] act, logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        e_valid = 1'b0; e_icode = 4'h0; e_ifun = 4'h0;
        alu_a = '0; alu_b = '0; alu_res = '0;
        e_stall = 1'b0; m_exc = 1'b0; w_exc = 1'b0;
    endtask

    // Drive each vector at negedge, queue its expectation, compare just after the next posedge.
    task automatic run_range(int lo, int hi);
        exp_t e;
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            e_valid = vecs[i].v;  e_icode = vecs[i].ic; e_ifun = vecs[i].fn;
            alu_a = vecs[i].a;    alu_b = vecs[i].b;    alu_res = vecs[i].r;
            e_stall = vecs[i].st; m_exc = vecs[i].me;   w_exc = vecs[i].we;
            e.idx = i; e.ez = vecs[i].ez; e.ef = vecs[i].ef;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
            e = exp_q.pop_front();
            $display("vec %0d: zso=%b frozen=%b (exp %b/%b)", e.idx, zso, frozen, e.ez, e.ef);
            check3($sformatf("vec%0d_zso", e.idx), zso, e.ez);
            check1($sformatf("vec%0d_frozen", e.idx), frozen, e.ef);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Table 1: main flag function, stall, m_exc, non-qualifying, freeze
        vecs.push_back(mk(1, 4'h6, 4'h0, MAXP, 64'd1, MSB, 0, 0, 0, 3'b011, 0)); // 0
        vecs.push_back(mk(1, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 0, 0, 0, 3'b100, 0)); // 1
        vecs.push_back(mk(1, 4'h6, 4'h2, MSB, MSB, MSB, 1, 0, 0, 3'b100, 0)); // 2
        vecs.push_back(mk(1, 4'h6, 4'h2, MSB, MSB, MSB, 1, 0, 0, 3'b100, 0)); // 3
        vecs.push_back(mk(1, 4'h6, 4'h2, MSB, MSB, MSB, 1, 0, 0, 3'b100, 0)); // 4
        vecs.push_back(mk(1, 4'h6, 4'h2, MSB, MSB, MSB, 0, 0, 0, 3'b010, 0)); // 5
        vecs.push_back(mk(1, 4'h6, 4'h0, 64'd1, 64'd2, 64'd3, 0, 1, 0, 3'b010, 0)); // 6
        vecs.push_back(mk(1, 4'h6, 4'h0, 64'd1, 64'd2, 64'd3, 0, 0, 0, 3'b000, 0)); // 7
        vecs.push_back(mk(0, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 3'b000, 0)); // 8 bubble
        vecs.push_back(mk(1, 4'h5, 4'h0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 3'b000, 0)); // 9 not OPq
        vecs.push_back(mk(1, 4'h6, 4'h4, 64'd0, 64'd0, 64'd0, 0, 0, 0, 3'b000, 0)); // 10 bad ifun
        vecs.push_back(mk(1, 4'h6, 4'h1, 64'd1, MSB, MAXP, 0, 0, 0, 3'b001, 0)); // 11 sub OF
        vecs.push_back(mk(1, 4'h6, 4'h3, ONES, ONES, 64'd0, 0, 0, 1, 3'b001, 1)); // 12 w_exc wins
        vecs.push_back(mk(1, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 3'b001, 1)); // 13 frozen
        vecs.push_back(mk(1, 4'h6, 4'h1, 64'd0, MSB, MSB, 0, 0, 0, 3'b001, 1)); // 14 frozen
        // Table 2: 5 qualifying OPqs and 2 bubbles
        vecs.push_back(mk(1, 4'h6, 4'h0, 64'd1, 64'd1, 64'd2, 0, 0, 0, 3'b000, 0)); // 15
        vecs.push_back(mk(0, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 3'b000, 0)); // 16 bubble
        vecs.push_back(mk(1, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 0, 0, 0, 3'b100, 0)); // 17
        vecs.push_back(mk(1, 4'h6, 4'h2, ONES, MSB, MSB, 0, 0, 0, 3'b010, 0)); // 18
        vecs.push_back(mk(0, 4'h6, 4'h3, 64'd1, 64'd1, 64'd0, 0, 0, 0, 3'b010, 0)); // 19 bubble
        vecs.push_back(mk(1, 4'h6, 4'h3, 64'd1, 64'd1, 64'd0, 0, 0, 0, 3'b100, 0)); // 20
        vecs.push_back(mk(1, 4'h6, 4'h1, 64'd1, 64'd0, ONES, 0, 0, 0, 3'b010, 0)); // 21

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check3("reset_zso", zso, 3'b100);
        check1("reset_frozen", frozen, 1'b0);
`ifdef CC_UPDCNT_EN
        check32("reset_upd_cnt", upd_cnt, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check3("idle_zso", zso, 3'b100);

        run_range(0, 14);

        // Async reset pulse away from any clock edge clears the freeze at once
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: zso=%b frozen=%b", zso, frozen);
        check3("async_rst_zso", zso, 3'b100);
        check1("async_rst_frozen", frozen, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        run_range(15, 21);
`ifdef CC_UPDCNT_EN
        $display("counter: upd_cnt=%0d", upd_cnt);
        check32("upd_cnt_after5", upd_cnt, 32'd5);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset: upd_cnt=%0d", upd_cnt);
        check32("upd_cnt_async_rst", upd_cnt, 32'd0);
        check3("async_rst2_zso", zso, 3'b100);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cc_reg.md
# cc_reg

Y86 condition-code register stage. It computes ZF/SF/OF from the execute-stage ALU operands and result, and latches them on qualifying OPq instructions. It presents the stored flags as a 3-bit ZSO bus, which the downstream condition evaluator uses to resolve jXX and cmovXX. Updates are suppressed on stall, on later-stage exceptions and after a committed exception.

## Interface
- W, 64, datapath word width in bits (must be ≥ 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- e_valid  in  1  execute stage holds a real (non-bubble) instruction
- e_icode  in  4  execute-stage icode
- e_ifun  in  4  ALU function: 0 add, 1 sub, 2 and, 3 xor
- alu_a  in  W  ALU operand valA
- alu_b  in  W  ALU operand valB
- alu_res  in  W  ALU result valE (valB OP valA)
- e_stall  in  1  execute stage stalled this cycle
- m_exc  in  1  memory stage holds an exception status (ADR/INS/HLT)
- w_exc  in  1  writeback stage holds an exception status
- zso  out  3  stored flags {ZF, SF, OF}; bit 2 = ZF, bit 1 = SF, bit 0 = OF
- frozen  out  1  CC permanently frozen by a committed exception
- upd_cnt  out  32  committed CC update count (only with CC_UPDCNT_EN)

## Operation
- Reset: zso = 3'b100 (ZF=1, SF=0, OF=0), frozen = 0, upd_cnt = 0.
- Flag generation (combinational, from the current inputs):
  - ZF = (alu_res == 0); SF = alu_res[W-1].
  - add: OF = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]).
  - sub (b − a): OF = (a[W-1] != b[W-1]) && (res[W-1] != b[W-1]).
  - and / xor: OF = 0.
- set_cc = e_valid && e_icode == 4'h6 && e_ifun ≤ 3 && !e_stall && !m_exc && !w_exc && !frozen.
- When set_cc is high, zso ← {ZF, SF, OF} at the next rising edge. Otherwise zso holds.
- OPq with e_ifun > 3: no update and no error output; decode reports INS.
- Freeze: w_exc high at a rising edge sets frozen = 1. frozen stays set until reset; zso then holds indefinitely.
- m_exc only suppresses updates and does not set frozen, because the memory-stage instruction may still be squashed.
- Simultaneous set_cc conditions and w_exc: w_exc wins. No update occurs and frozen sets in the same edge.

## Timing
- Latency: exactly 1 cycle. Flags from an OPq in E appear on zso at the next cycle, in time for a jXX/cmovXX in E the following cycle.
- No combinational path from any input to zso or frozen; both are registered.
- Reset mid-operation: asserting rst_n low immediately forces all reset values, independent of clk. Deassertion is expected synchronous to clk (synchronized upstream).
- A stall held across N cycles produces zero updates. The update occurs on the first unstalled edge with valid inputs.
- Back-to-back OPq: each qualifying cycle overwrites zso. The last qualifying instruction wins.

## Configuration
- CC_UPDCNT_EN defined:
  - upd_cnt port exists.
  - It increments by 1 on every edge where set_cc is high.
  - It wraps 32'hFFFF_FFFF → 0 and resets to 0.
- CC_UPDCNT_EN undefined: the upd_cnt port and its counter logic are absent. All other behaviour is identical.

## Structure
- Shared package y86_pkg:
  - icode constant IOPQ = 4'h6.
  - ALU function constants ALUADD/ALUSUB/ALUAND/ALUXOR.
  - ZSO bit-index constants ZF_B = 2, SF_B = 1, OF_B = 0.
  - CC_RST = 3'b100.
- One sub-module, cc_flags: the purely combinational flag generator (W-parameterised; inputs ifun, a, b, res; output 3-bit flags). cc_reg contains the gating, register, freeze and counter.

## Test plan
- Reset, no activity → zso = 3'b100, frozen = 0, upd_cnt = 0.
- W=64, add a = 0x7FFF_FFFF_FFFF_FFFF, b = 1, res = 0x8000_0000_0000_0000 → next cycle zso = 3'b011. Then sub a = 5, b = 5, res = 0 → zso = 3'b100.
- and a = b = res = 0x8000_0000_0000_0000 with e_stall = 1 for 3 cycles → zso unchanged. Release stall → zso = 3'b010 one cycle later.
- OPq add with m_exc = 1 → no change and frozen stays 0. Same OPq with m_exc = 0 → updates.
- w_exc = 1 concurrent with a qualifying xor producing res = 0 → zso unchanged and frozen = 1. Later OPqs → no update until rst_n pulse restores 3'b100.
- With CC_UPDCNT_EN, 5 qualifying OPqs plus 2 bubbles (e_valid = 0) → upd_cnt = 5. Async reset mid-sequence → upd_cnt = 0 immediately.
